// File: rtl/mips_id_ex_stage.sv
// MIPS32 decode / operand-fetch stage with writeback bypass, load-use interlock and ID/EX register.
// Optional build macro: ZERO_REG_EN (R0 hardwired to zero).
module mips_id_ex_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RIDX_W = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_instr,
  input  logic [DATA_W-1:0] in_npc,
  output logic [RIDX_W-1:0] sr1,
  output logic [RIDX_W-1:0] sr2,
  input  logic [DATA_W-1:0] rdData1,
  input  logic [DATA_W-1:0] rdData2,
  input  logic              wb_write,
  input  logic [RIDX_W-1:0] wb_dr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        ex_type,
  output logic [5:0]        ex_op,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [DATA_W-1:0] ex_imm,
  output logic [RIDX_W-1:0] ex_dr,
  output logic              ex_wr_en,
  output logic [DATA_W-1:0] ex_npc,
  output logic              halted
);

  localparam logic [2:0] TyRrAlu  = 3'd0;
  localparam logic [2:0] TyRmAlu  = 3'd1;
  localparam logic [2:0] TyLoad   = 3'd2;
  localparam logic [2:0] TyStore  = 3'd3;
  localparam logic [2:0] TyBranch = 3'd4;
  localparam logic [2:0] TyHalt   = 3'd5;
  localparam logic [2:0] TyInvalid = 3'd7;

  logic [5:0]        op;
  logic [2:0]        d_type;
  logic [RIDX_W-1:0] d_dr;
  logic              d_wr;
  logic              rs_used;
  logic              rt_used;
  logic [DATA_W-1:0] d_imm;
  logic [DATA_W-1:0] opnd_a;
  logic [DATA_W-1:0] opnd_b;
  logic              byp_a;
  logic              byp_b;
  logic              hz;
  logic              adv;
  logic              xfer;

  assign op    = in_instr[31:26];
  assign sr1   = in_instr[21 +: RIDX_W];
  assign sr2   = in_instr[16 +: RIDX_W];
  assign d_imm = {{(DATA_W-16){in_instr[15]}}, in_instr[15:0]};

  always_comb begin
    d_type  = TyInvalid;
    d_dr    = '0;
    d_wr    = 1'b0;
    rs_used = 1'b0;
    rt_used = 1'b0;
    case (op)
      6'b000000, 6'b000001, 6'b000010, 6'b000011, 6'b000100, 6'b000101: begin
        d_type  = TyRrAlu;
        d_dr    = in_instr[11 +: RIDX_W];
        d_wr    = 1'b1;
        rs_used = 1'b1;
        rt_used = 1'b1;
      end
      6'b001010, 6'b001011, 6'b001100: begin
        d_type  = TyRmAlu;
        d_dr    = sr2;
        d_wr    = 1'b1;
        rs_used = 1'b1;
      end
      6'b001000: begin
        d_type  = TyLoad;
        d_dr    = sr2;
        d_wr    = 1'b1;
        rs_used = 1'b1;
      end
      6'b001001: begin
        d_type  = TyStore;
        rs_used = 1'b1;
        rt_used = 1'b1;
      end
      6'b001101, 6'b001110: begin
        d_type  = TyBranch;
        rs_used = 1'b1;
      end
      6'b111111: d_type = TyHalt;
      default:   d_type = TyInvalid;
    endcase
`ifdef ZERO_REG_EN
    if (d_dr == '0) d_wr = 1'b0;
`endif
  end

  // Regfile write lands on the edge, so a same-cycle writeback must be forwarded here.
`ifdef ZERO_REG_EN
  assign byp_a  = wb_write && (wb_dr == sr1) && (wb_dr != '0);
  assign byp_b  = wb_write && (wb_dr == sr2) && (wb_dr != '0);
  assign opnd_a = (sr1 == '0) ? '0 : (byp_a ? wb_data : rdData1);
  assign opnd_b = (sr2 == '0) ? '0 : (byp_b ? wb_data : rdData2);
  assign hz     = out_valid && (ex_type == TyLoad) && ex_wr_en && (ex_dr != '0) &&
                  ((rs_used && (ex_dr == sr1)) || (rt_used && (ex_dr == sr2)));
`else
  assign byp_a  = wb_write && (wb_dr == sr1);
  assign byp_b  = wb_write && (wb_dr == sr2);
  assign opnd_a = byp_a ? wb_data : rdData1;
  assign opnd_b = byp_b ? wb_data : rdData2;
  assign hz     = out_valid && (ex_type == TyLoad) && ex_wr_en &&
                  ((rs_used && (ex_dr == sr1)) || (rt_used && (ex_dr == sr2)));
`endif

  assign adv      = out_ready || !out_valid;
  // Flush consumes the wrong-path input regardless of stall state.
  assign in_ready = reset_n && (flush || (adv && !hz && !halted));
  assign xfer     = in_valid && in_ready && !flush;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      halted    <= 1'b0;
      ex_type   <= '0;
      ex_op     <= '0;
      ex_a      <= '0;
      ex_b      <= '0;
      ex_imm    <= '0;
      ex_dr     <= '0;
      ex_wr_en  <= 1'b0;
      ex_npc    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      halted    <= 1'b0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      ex_type   <= d_type;
      ex_op     <= op;
      ex_a      <= opnd_a;
      ex_b      <= opnd_b;
      ex_imm    <= d_imm;
      ex_dr     <= d_dr;
      ex_wr_en  <= d_wr;
      ex_npc    <= in_npc;
      if (d_type == TyHalt) halted <= 1'b1;
    end else if (adv) begin
      // Covers idle, halted and load-use bubble cycles.
      out_valid <= 1'b0;
    end
  end

endmodule
